i2s_audio_rx: RTL and testbench

Slave-mode I2S receiver: the capture counterpart of the DAC I2S transmitter path in the AudVid audio/video subsystem. It samples externally driven bit clock, word select and serial data into the system clock domain. It deserializes left/right words (MSB first, standard I2S one-bit delay) and presents each stereo pair on a valid/ready output for the audio buffer logic. Intended sources are an external ADC/codec, or loopback of the design's own DAC I2S outputs for self-test.

---
 rtl/i2s_audio_rx.sv | 155 +++++++++++++++
 tb/tb_i2s_audio_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_rx.sv
// rtl/i2s_audio_rx.sv - slave-mode I2S receiver, stereo pairs on valid/ready; optional overrun counter via I2S_RX_OVERRUN_COUNT_EN
`timescale 1ns/1ps
module i2s_audio_rx #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    I2S_BCLK,
    input  logic                    I2S_WS,
    input  logic                    I2S_DATA,
    output logic [SAMPLE_WIDTH-1:0] SampleLeft,
    output logic [SAMPLE_WIDTH-1:0] SampleRight,
    output logic                    SampleValid,
    input  logic                    SampleReady,
    output logic                    Overrun,
    output logic [15:0]             OverrunCount
);
    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [2:0]              bclk_sync;
    logic [1:0]              ws_sync;
    logic [1:0]              data_sync;
    logic                    bit_edge;
    logic                    ws_bit;
    logic                    data_bit;
    logic                    word_end;
    logic                    ws_prev;
    logic                    ws_prev_ok;
    logic [1:0]              state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SAMPLE_WIDTH-1:0] shift_word;
    logic [SAMPLE_WIDTH-1:0] word_next;
    logic [SAMPLE_WIDTH-1:0] left_word;
    logic                    left_seen;
    logic                    pair_done;
    logic [SAMPLE_WIDTH-1:0] pair_left;
    logic [SAMPLE_WIDTH-1:0] pair_right;
    logic                    load;

    // Two-flop synchronizers on all pins; the third BCLK flop feeds the rising-edge detector.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            bclk_sync <= '0;
            ws_sync   <= '0;
            data_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], I2S_BCLK};
            ws_sync   <= {ws_sync[0], I2S_WS};
            data_sync <= {data_sync[0], I2S_DATA};
        end
    end

    assign bit_edge = bclk_sync[1] & ~bclk_sync[2];
    assign ws_bit   = ws_sync[1];
    assign data_bit = data_sync[1];
    // The first edge after reset only primes ws_prev, so a WS level present at release is not a transition.
    assign word_end = bit_edge & ws_prev_ok & (ws_bit != ws_prev);

    // Place the current bit MSB-first; bits beyond SAMPLE_WIDTH match no index and are dropped.
    always_comb begin
        word_next = shift_word;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (bit_cnt == CNT_W'(SAMPLE_WIDTH - 1 - i)) begin
                word_next[i] = data_bit;
            end
        end
    end

    // Deserializer and frame-sync state machine, advanced once per bit edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ws_prev    <= 1'b0;
            ws_prev_ok <= 1'b0;
            state      <= ST_HUNT;
            bit_cnt    <= '0;
            shift_word <= '0;
            left_word  <= '0;
            left_seen  <= 1'b0;
            pair_done  <= 1'b0;
            pair_left  <= '0;
            pair_right <= '0;
        end else begin
            pair_done <= 1'b0;
            if (bit_edge) begin
                ws_prev    <= ws_bit;
                ws_prev_ok <= 1'b1;
                if (word_end) begin
                    shift_word <= '0;
                    bit_cnt    <= '0;
                    case (state)
                        ST_LEFT: begin
                            left_word <= word_next;
                            left_seen <= 1'b1;
                            state     <= ST_RIGHT;
                        end
                        ST_RIGHT: begin
                            if (left_seen) begin
                                pair_done  <= 1'b1;
                                pair_left  <= left_word;
                                pair_right <= word_next;
                            end
                            left_seen <= 1'b0;
                            state     <= ST_LEFT;
                        end
                        default: state <= ws_bit ? ST_RIGHT : ST_LEFT;
                    endcase
                end else begin
                    shift_word <= word_next;
                    if (bit_cnt != CNT_W'(SAMPLE_WIDTH)) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign load = pair_done & (~SampleValid | SampleReady);

    // Output holding register: load when empty or being drained, otherwise drop and flag overrun.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            SampleLeft  <= '0;
            SampleRight <= '0;
            SampleValid <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            Overrun <= pair_done & ~load;
            if (load) begin
                SampleLeft  <= pair_left;
                SampleRight <= pair_right;
                SampleValid <= 1'b1;
            end else if (SampleValid & SampleReady) begin
                SampleValid <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVERRUN_COUNT_EN
    // Saturating count of dropped pairs, cleared only by reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            OverrunCount <= '0;
        end else if (pair_done & ~load & (OverrunCount != 16'hFFFF)) begin
            OverrunCount <= OverrunCount + 16'd1;
        end
    end
`else
    assign OverrunCount = 16'h0000;
`endif

endmodule

// File: tb/tb_i2s_audio_rx.sv
// tb/tb_i2s_audio_rx.sv - self-checking bench for i2s_audio_rx
`timescale 1ns/1ps
module tb_i2s_audio_rx;
    localparam int W = 16;
`ifdef I2S_RX_OVERRUN_COUNT_EN
    localparam int EXP_OVR_CNT = 2;
`else
    localparam int EXP_OVR_CNT = 0;
`endif

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          I2S_BCLK = 1'b0;
    logic          I2S_WS = 1'b0;
    logic          I2S_DATA = 1'b0;
    logic          SampleReady = 1'b0;
    logic [W-1:0]  SampleLeft;
    logic [W-1:0]  SampleRight;
    logic          SampleValid;
    logic          Overrun;
    logic [15:0]   OverrunCount;

    i2s_audio_rx #(.SAMPLE_WIDTH(W)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .I2S_BCLK     (I2S_BCLK),
        .I2S_WS       (I2S_WS),
        .I2S_DATA     (I2S_DATA),
        .SampleLeft   (SampleLeft),
        .SampleRight  (SampleRight),
        .SampleValid  (SampleValid),
        .SampleReady  (SampleReady),
        .Overrun      (Overrun),
        .OverrunCount (OverrunCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          ln;
        logic [31:0] lval;
        int          rn;
        logic [31:0] rval;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    pair_t exp_q[$];
    pair_t mon_p;
    vec_t  vecs[6];
    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    valid_rise_cyc = -1;
    int    valid_hi = 0;
    int    ovr_seen = 0;
    int    last_rise_cyc = 0;
    int    lsb_cyc;
    logic  prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: samples between edges; a pair is consumed when valid&ready before the next posedge.
    always begin
        @(negedge CLK);
        #3;
        if (SampleValid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = SampleValid;
        if (SampleValid) valid_hi++;
        if (Overrun) ovr_seen++;
        if (SampleValid && SampleReady) begin
            check("pair_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_p = exp_q.pop_front();
                check("pair_left", 32'(SampleLeft), 32'(mon_p.l));
                check("pair_right", 32'(SampleRight), 32'(mon_p.r));
            end
        end
    end

    // One BCLK period of 8 CLK: WS/DATA change with the falling edge, rising edge mid-period.
    task automatic slot(input logic d, input logic w);
        @(negedge CLK);
        I2S_BCLK = 1'b0;
        I2S_WS   = w;
        I2S_DATA = d;
        repeat (4) @(negedge CLK);
        I2S_BCLK = 1'b1;
        last_rise_cyc = cyc;
        repeat (3) @(negedge CLK);
    endtask

    // n-bit word on channel c; the LSB slot already carries the next channel's WS.
    task automatic send_word(input logic [31:0] v, input int n, input logic c, input logic cn);
        for (int i = n - 1; i >= 0; i--) slot(v[i], (i == 0) ? cn : c);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset    = 1'b0;
        I2S_BCLK = 1'b0;
        I2S_WS   = 1'b0;
        I2S_DATA = 1'b0;
        repeat (3) @(negedge CLK);
        exp_q.delete();
        Reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16, 32'hA5C3,   16, 32'h1234,   16'hA5C3, 16'h1234};
        vecs[1] = '{24, 32'h89ABCD, 24, 32'hFEDCBA, 16'h89AB, 16'hFEDC};
        vecs[2] = '{8,  32'h55,     8,  32'h7F,     16'h5500, 16'h7F00};
        vecs[3] = '{16, 32'hFFFF,   16, 32'h0001,   16'hFFFF, 16'h0001};
        vecs[4] = '{20, 32'hF0F0F,  12, 32'hABC,    16'hF0F0, 16'hABC0};
        vecs[5] = '{17, 32'h18001,  15, 32'h7FFF,   16'hC000, 16'hFFFE};

        // Reset state
        #2 Reset = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_left", 32'(SampleLeft), 32'd0);
        check("rst_right", 32'(SampleRight), 32'd0);
        check("rst_valid", 32'(SampleValid), 32'd0);
        check("rst_overrun", 32'(Overrun), 32'd0);
        check("rst_ovr_count", 32'(OverrunCount), 32'd0);
        Reset = 1'b1;

        // Table-driven continuous stream with SampleReady held high
        do_reset();
        SampleReady = 1'b1;
        valid_hi = 0;
        ovr_seen = 0;
        send_word(32'h0, 16, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send_word(vecs[k].lval, vecs[k].ln, 1'b0, 1'b1);
            exp_q.push_back('{vecs[k].exp_l, vecs[k].exp_r});
            send_word(vecs[k].rval, vecs[k].rn, 1'b1, 1'b0);
            lsb_cyc = last_rise_cyc;
            repeat (2) @(negedge CLK);
            check("latency", 32'(valid_rise_cyc - lsb_cyc), 32'd4);
        end
        repeat (4) slot(1'b0, 1'b0);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_valid_cycles", 32'(valid_hi), 32'd6);
        check("stream_no_overrun", 32'(ovr_seen), 32'd0);

        // Backpressure: three frames with SampleReady low
        do_reset();
        SampleReady = 1'b0;
        ovr_seen = 0;
        send_word(32'h0, 16, 1'b1, 1'b0);
        exp_q.push_back('{16'h1111, 16'h2222});
        send_word(32'h1111, 16, 1'b0, 1'b1);
        send_word(32'h2222, 16, 1'b1, 1'b0);
        send_word(32'h3333, 16, 1'b0, 1'b1);
        send_word(32'h4444, 16, 1'b1, 1'b0);
        send_word(32'h5555, 16, 1'b0, 1'b1);
        send_word(32'h6666, 16, 1'b1, 1'b0);
        repeat (6) @(negedge CLK);
        check("bp_valid", 32'(SampleValid), 32'd1);
        check("bp_left_held", 32'(SampleLeft), 32'h1111);
        check("bp_right_held", 32'(SampleRight), 32'h2222);
        check("bp_overrun_pulses", 32'(ovr_seen), 32'd2);
        check("bp_overrun_count", 32'(OverrunCount), 32'(EXP_OVR_CNT));

        // Reset during the 9th bit of a left word
        for (int i = 15; i >= 8; i--) slot(1'(16'hC3A5 >> i), 1'b0);
        @(negedge CLK);
        I2S_BCLK = 1'b0;
        I2S_DATA = 1'(16'hC3A5 >> 7);
        repeat (4) @(negedge CLK);
        I2S_BCLK = 1'b1;
        @(negedge CLK);
        #1 Reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(SampleValid), 32'd0);
        check("mid_rst_left", 32'(SampleLeft), 32'd0);
        check("mid_rst_right", 32'(SampleRight), 32'd0);
        check("mid_rst_overrun", 32'(Overrun), 32'd0);
        check("mid_rst_count", 32'(OverrunCount), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        SampleReady = 1'b1;
        ovr_seen = 0;
        for (int i = 6; i >= 0; i--) slot(1'(16'hC3A5 >> i), (i == 0) ? 1'b1 : 1'b0);
        send_word(32'h0F0F, 16, 1'b1, 1'b0);
        repeat (6) @(negedge CLK);
        check("orphan_right_dropped", 32'(SampleValid), 32'd0);
        exp_q.push_back('{16'hBEEF, 16'hCAFE});
        send_word(32'hBEEF, 16, 1'b0, 1'b1);
        send_word(32'hCAFE, 16, 1'b1, 1'b0);
        repeat (3) slot(1'b0, 1'b0);
        check("mid_rst_drained", 32'(exp_q.size()), 32'd0);
        check("mid_rst_no_overrun", 32'(ovr_seen), 32'd0);

        // Startup alignment: release reset in the middle of a right word
        @(negedge CLK);
        Reset = 1'b0;
        exp_q.delete();
        for (int i = 15; i >= 11; i--) slot(1'(16'h9999 >> i), 1'b1);
        Reset = 1'b1;
        for (int i = 10; i >= 0; i--) slot(1'(16'h9999 >> i), (i == 0) ? 1'b0 : 1'b1);
        exp_q.push_back('{16'h0123, 16'h4567});
        send_word(32'h0123, 16, 1'b0, 1'b1);
        check("startup_no_early_pair", 32'(SampleValid), 32'd0);
        send_word(32'h4567, 16, 1'b1, 1'b0);
        repeat (3) slot(1'b0, 1'b0);
        check("startup_drained", 32'(exp_q.size()), 32'd0);

        // Accept and load in the same cycle
        do_reset();
        SampleReady = 1'b0;
        ovr_seen = 0;
        send_word(32'h0, 16, 1'b1, 1'b0);
        exp_q.push_back('{16'h1357, 16'h2468});
        send_word(32'h1357, 16, 1'b0, 1'b1);
        send_word(32'h2468, 16, 1'b1, 1'b0);
        repeat (4) @(negedge CLK);
        check("acc_first_valid", 32'(SampleValid), 32'd1);
        exp_q.push_back('{16'h9ABC, 16'hDEF0});
        send_word(32'h9ABC, 16, 1'b0, 1'b1);
        send_word(32'hDEF0, 16, 1'b1, 1'b0);
        SampleReady = 1'b1;
        @(negedge CLK);
        SampleReady = 1'b0;
        #1;
        check("acc_valid_kept", 32'(SampleValid), 32'd1);
        check("acc_new_left", 32'(SampleLeft), 32'h9ABC);
        check("acc_new_right", 32'(SampleRight), 32'hDEF0);
        check("acc_no_overrun", 32'(Overrun), 32'd0);
        repeat (3) @(negedge CLK);
        SampleReady = 1'b1;
        repeat (4) @(negedge CLK);
        check("acc_drained", 32'(exp_q.size()), 32'd0);
        check("acc_no_overrun_seen", 32'(ovr_seen), 32'd0);
        check("acc_valid_cleared", 32'(SampleValid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
